// File: rtl/uart_clk_div_n.sv
// Baud-rate clock generator: divides clk_in by DIV into a registered square wave
// that runs only while a frame is being transmitted and restarts at phase zero.
module uart_clk_div_n #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int BAUD     = 9600
) (
    input  logic clk_in,
    input  logic rst,
    input  logic transmission_state,
    output logic clk_out
);

    localparam int DIV  = CLK_FREQ / BAUD;
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);

    generate
        if (DIV < 2) begin : g_div_check
            $error("uart_clk_div_n: CLK_FREQ/BAUD must be at least 2");
        end
    endgenerate

    localparam logic [CW-1:0] LAST_CNT = CW'(DIV - 1);
    localparam logic [CW-1:0] RISE_CNT = CW'(HALF - 1);

    logic [CW-1:0] r_cnt;
    logic          r_clk_out;
    logic          w_last;
    logic          w_rise;

    assign w_last  = (r_cnt == LAST_CNT);
    assign w_rise  = (r_cnt == RISE_CNT);
    assign clk_out = r_clk_out;

    // Idle is treated like reset so every frame starts from the same phase.
    always_ff @(posedge clk_in) begin
        if (rst || !transmission_state) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else if (w_last) begin
            r_cnt     <= '0;
            r_clk_out <= 1'b0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (w_rise) begin
                r_clk_out <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_clk_div_n.sv
// Directed bench for uart_clk_div_n: default 50 MHz/9600 divider plus
// DIV=10 and DIV=11 instances for waveform-shape checks.
module tb_uart_clk_div_n;

    logic       clk_in;
    logic       rst;
    logic       transmission_state;
    logic [2:0] w_co;

    int checks = 0;
    int errors = 0;
    int n;
    int n_hi;
    int n_lo;

    uart_clk_div_n u_dut_default (
        .clk_in             (clk_in),
        .rst                (rst),
        .transmission_state (transmission_state),
        .clk_out            (w_co[0])
    );

    uart_clk_div_n #(.CLK_FREQ(1000), .BAUD(100)) u_dut_div10 (
        .clk_in             (clk_in),
        .rst                (rst),
        .transmission_state (transmission_state),
        .clk_out            (w_co[1])
    );

    uart_clk_div_n #(.CLK_FREQ(1100), .BAUD(100)) u_dut_div11 (
        .clk_in             (clk_in),
        .rst                (rst),
        .transmission_state (transmission_state),
        .clk_out            (w_co[2])
    );

    initial begin
        clk_in = 1'b0;
        forever #10 clk_in = ~clk_in;
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Counts rising edges (sampled on the following falling edge) until the
    // selected output reaches lvl; returns -1 if the limit expires.
    task automatic wait_level(input int sel, input logic lvl, input int limit, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk_in);
            cnt++;
        end while (w_co[sel] !== lvl && cnt < limit);
        if (w_co[sel] !== lvl) cnt = -1;
    endtask

    task automatic count_highs(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk_in);
            if (w_co !== 3'b000) highs++;
        end
    endtask

    initial begin
        rst                = 1'b1;
        transmission_state = 1'b0;

        // Reset: first rising edge at 10 ns
        #15;
        check("reset_default", int'(w_co[0]), 0);
        check("reset_div10",   int'(w_co[1]), 0);
        check("reset_div11",   int'(w_co[2]), 0);

        @(negedge clk_in);
        transmission_state = 1'b1;
        count_highs(50, n);
        check("reset_holds_with_ts", n, 0);

        // Idle
        rst                = 1'b0;
        transmission_state = 1'b0;
        count_highs(2000, n);
        check("idle_no_toggle", n, 0);

        // Active: default divider
        transmission_state = 1'b1;
        wait_level(0, 1'b1, 6000, n);
        check("first_rise", n, 2604);
        wait_level(0, 1'b0, 6000, n_hi);
        check("high_time", n_hi, 2604);
        wait_level(0, 1'b1, 6000, n_lo);
        check("low_time", n_lo, 2604);
        check("period", n_hi + n_lo, 5208);
        wait_level(0, 1'b0, 6000, n_hi);
        wait_level(0, 1'b1, 6000, n_lo);
        check("period_2", n_hi + n_lo, 5208);

        // Drop to idle while clk_out is high
        wait_level(0, 1'b1, 10, n);
        transmission_state = 1'b0;
        @(negedge clk_in);
        check("idle_drop_clears", int'(w_co[0]), 0);
        count_highs(2000, n);
        check("idle_after_drop", n, 0);
        transmission_state = 1'b1;
        wait_level(0, 1'b1, 6000, n);
        check("reassert_first_rise", n, 2604);

        // Single-cycle reset during the high phase
        repeat (100) @(negedge clk_in);
        check("high_before_reset", int'(w_co[0]), 1);
        rst = 1'b1;
        @(negedge clk_in);
        rst = 1'b0;
        check("mid_reset_clears", int'(w_co[0]), 0);
        wait_level(0, 1'b1, 6000, n);
        check("rise_after_reset", n, 2604);

        // Single-cycle idle gap during the high phase
        repeat (100) @(negedge clk_in);
        transmission_state = 1'b0;
        @(negedge clk_in);
        transmission_state = 1'b1;
        check("gap_clears", int'(w_co[0]), 0);
        wait_level(0, 1'b1, 6000, n);
        check("rise_after_gap", n, 2604);

        // DIV=10: 5 low / 5 high
        transmission_state = 1'b0;
        @(negedge clk_in);
        transmission_state = 1'b1;
        wait_level(1, 1'b1, 50, n);
        check("div10_first_rise", n, 5);
        wait_level(1, 1'b0, 50, n_hi);
        check("div10_high", n_hi, 5);
        wait_level(1, 1'b1, 50, n_lo);
        check("div10_low", n_lo, 5);

        // DIV=11: 5 low / 6 high
        transmission_state = 1'b0;
        @(negedge clk_in);
        transmission_state = 1'b1;
        wait_level(2, 1'b1, 50, n);
        check("div11_first_rise", n, 5);
        wait_level(2, 1'b0, 50, n_hi);
        check("div11_high", n_hi, 6);
        wait_level(2, 1'b1, 50, n_lo);
        check("div11_low", n_lo, 5);
        check("div11_period", n_hi + n_lo, 11);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
